// File: rtl/pipe_hazard_ctrl_if.sv
// pipe_hazard_ctrl_if: hazard-control signals between the pipeline datapath (master)
// and the hazard controller (slave).
interface pipe_hazard_ctrl_if #(
   parameter int PERF_W = 32
);
   logic [4:0]        if_id_rs1;
   logic [4:0]        if_id_rs2;
   logic              id_ex_memread;
   logic [4:0]        id_ex_rd;
   logic              ex_mem_branch;
   logic              ex_mem_zero;
   logic              ex_mem_memread;
   logic              ex_mem_memwrite;
   logic              dmem_ready;
   logic              dmem_req;
   logic              pc_write;
   logic              pc_sel;
   logic              if_id_write;
   logic              if_id_flush;
   logic              id_ex_flush;
   logic              ex_mem_flush;
   logic              pipe_hold;
   logic              mem_err;
   logic [PERF_W-1:0] stall_cycles;
   logic [PERF_W-1:0] flush_count;

   modport master (
      output if_id_rs1, if_id_rs2, id_ex_memread, id_ex_rd, ex_mem_branch, ex_mem_zero,
             ex_mem_memread, ex_mem_memwrite, dmem_ready,
      input  dmem_req, pc_write, pc_sel, if_id_write, if_id_flush, id_ex_flush,
             ex_mem_flush, pipe_hold, mem_err, stall_cycles, flush_count
   );

   modport slave (
      input  if_id_rs1, if_id_rs2, id_ex_memread, id_ex_rd, ex_mem_branch, ex_mem_zero,
             ex_mem_memread, ex_mem_memwrite, dmem_ready,
      output dmem_req, pc_write, pc_sel, if_id_write, if_id_flush, id_ex_flush,
             ex_mem_flush, pipe_hold, mem_err, stall_cycles, flush_count
   );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: load-use/branch hazard and data-memory wait controller for a 5-stage pipeline.
// Define PIPE_HAZARD_PERF_CNT_EN to build the saturating stall/flush performance counters.
module pipe_hazard_ctrl #(
   parameter int MEM_TIMEOUT = 16,
   parameter int PERF_W      = 32
) (
   input logic               clk,
   input logic               reset_n,
   pipe_hazard_ctrl_if.slave bus
);
   localparam int CW = $clog2(MEM_TIMEOUT);

   typedef enum logic [1:0] {RUN = 2'b00, MEM_WAIT = 2'b01, HALT = 2'b10} state_t;

   state_t          r_state;
   logic [CW-1:0]   r_cnt;
   logic            r_err;
   state_t          w_cur;
   state_t          w_next;
   logic [CW-1:0]   w_cnt_next;
   logic            w_err_set;
   logic            w_access;
   logic            w_taken;
   logic            w_lu;
   logic            w_decode;
   logic            w_dmem_req;
   logic            w_pc_write;
   logic            w_pc_sel;
   logic            w_if_id_write;
   logic            w_if_id_flush;
   logic            w_id_ex_flush;
   logic            w_ex_mem_flush;
   logic            w_pipe_hold;

   // Outputs decode as RUN while reset is held so the datapath sees sane controls.
   assign w_cur    = reset_n ? r_state : RUN;
   assign w_access = bus.ex_mem_memread | bus.ex_mem_memwrite;
   assign w_taken  = bus.ex_mem_branch & bus.ex_mem_zero;
   assign w_lu     = bus.id_ex_memread & (bus.id_ex_rd != 5'd0) &
                     ((bus.id_ex_rd == bus.if_id_rs1) | (bus.id_ex_rd == bus.if_id_rs2));

   always_comb begin
      w_next         = w_cur;
      w_cnt_next     = r_cnt;
      w_err_set      = 1'b0;
      w_decode       = 1'b0;
      w_dmem_req     = 1'b0;
      w_pc_write     = 1'b1;
      w_pc_sel       = 1'b0;
      w_if_id_write  = 1'b1;
      w_if_id_flush  = 1'b0;
      w_id_ex_flush  = 1'b0;
      w_ex_mem_flush = 1'b0;
      w_pipe_hold    = 1'b0;
      if (w_cur == RUN) begin
         w_dmem_req = w_access;
         if (w_access && !bus.dmem_ready) begin
            w_pipe_hold   = 1'b1;
            w_pc_write    = 1'b0;
            w_if_id_write = 1'b0;
            w_next        = MEM_WAIT;
            w_cnt_next    = '0;
         end else begin
            w_decode = 1'b1;
         end
      end else if (w_cur == MEM_WAIT) begin
         w_dmem_req = 1'b1;
         if (!bus.dmem_ready) begin
            w_pipe_hold   = 1'b1;
            w_pc_write    = 1'b0;
            w_if_id_write = 1'b0;
            // Leave the counter alone on the timeout edge so it never wraps.
            if (r_cnt == CW'(MEM_TIMEOUT - 1)) begin
               w_next    = HALT;
               w_err_set = 1'b1;
            end else begin
               w_cnt_next = r_cnt + 1'b1;
            end
         end else begin
            w_decode = 1'b1;
            w_next   = RUN;
         end
      end else begin
         w_pipe_hold   = 1'b1;
         w_pc_write    = 1'b0;
         w_if_id_write = 1'b0;
         w_next        = HALT;
      end
      // A taken branch squashes the younger load-use pair, so it wins.
      if (w_decode) begin
         if (w_taken) begin
            w_pc_sel       = 1'b1;
            w_if_id_flush  = 1'b1;
            w_id_ex_flush  = 1'b1;
            w_ex_mem_flush = 1'b1;
         end else if (w_lu) begin
            w_pc_write    = 1'b0;
            w_if_id_write = 1'b0;
            w_id_ex_flush = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state <= RUN;
         r_cnt   <= '0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_next;
         r_cnt   <= w_cnt_next;
         r_err   <= r_err | w_err_set;
      end
   end

   assign bus.dmem_req     = w_dmem_req;
   assign bus.pc_write     = w_pc_write;
   assign bus.pc_sel       = w_pc_sel;
   assign bus.if_id_write  = w_if_id_write;
   assign bus.if_id_flush  = w_if_id_flush;
   assign bus.id_ex_flush  = w_id_ex_flush;
   assign bus.ex_mem_flush = w_ex_mem_flush;
   assign bus.pipe_hold    = w_pipe_hold;
   assign bus.mem_err      = r_err;

`ifdef PIPE_HAZARD_PERF_CNT_EN
   logic [PERF_W-1:0] r_stall;
   logic [PERF_W-1:0] r_flush;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_stall <= '0;
         r_flush <= '0;
      end else begin
         if (!w_pc_write && !(&r_stall)) r_stall <= r_stall + 1'b1;
         if (w_pc_sel && !(&r_flush)) r_flush <= r_flush + 1'b1;
      end
   end

   assign bus.stall_cycles = r_stall;
   assign bus.flush_count  = r_flush;
`else
   assign bus.stall_cycles = {PERF_W{1'b0}};
   assign bus.flush_count  = {PERF_W{1'b0}};
`endif
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed scoreboard bench for pipe_hazard_ctrl (MEM_TIMEOUT=4).
// Output vector order: dmem_req, pc_write, pc_sel, if_id_write, if_id/id_ex/ex_mem flush, pipe_hold, mem_err.
module tb_pipe_hazard_ctrl;
   localparam int MT = 4;
   localparam int PW = 32;

   localparam logic [8:0] NORM  = 9'b010100000;
   localparam logic [8:0] LU    = 9'b000001000;
   localparam logic [8:0] BR    = 9'b011111100;
   localparam logic [8:0] HOLD  = 9'b100000010;
   localparam logic [8:0] DNORM = 9'b110100000;
   localparam logic [8:0] DBR   = 9'b111111100;
   localparam logic [8:0] HLT   = 9'b000000011;
   localparam logic [8:0] NERR  = 9'b010100001;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   pipe_hazard_ctrl_if #(.PERF_W(PW)) bus ();
   pipe_hazard_ctrl #(.MEM_TIMEOUT(MT), .PERF_W(PW)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

   logic [8:0]    obs;
   logic [8:0]    q[$];
   int            n_vec = 0;
   int            n_miss = 0;
   logic [PW-1:0] exp_stall = '0;
   logic [PW-1:0] exp_flush = '0;

   assign obs = {bus.dmem_req, bus.pc_write, bus.pc_sel, bus.if_id_write, bus.if_id_flush,
                 bus.id_ex_flush, bus.ex_mem_flush, bus.pipe_hold, bus.mem_err};

   task automatic step(input string tag, input logic rst_n, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, input logic memrd, input logic br, input logic zero,
                       input logic exrd, input logic exwr, input logic rdy, input logic [8:0] exp);
      logic [8:0] e;
      @(negedge clk);
      n_vec++;
      assert (bus.stall_cycles === exp_stall) else begin
         n_miss++;
         $error("FAIL %s stall_cycles got %0d expected %0d", tag, bus.stall_cycles, exp_stall);
      end
      n_vec++;
      assert (bus.flush_count === exp_flush) else begin
         n_miss++;
         $error("FAIL %s flush_count got %0d expected %0d", tag, bus.flush_count, exp_flush);
      end
      reset_n             = rst_n;
      bus.if_id_rs1       = rs1;
      bus.if_id_rs2       = rs2;
      bus.id_ex_rd        = rd;
      bus.id_ex_memread   = memrd;
      bus.ex_mem_branch   = br;
      bus.ex_mem_zero     = zero;
      bus.ex_mem_memread  = exrd;
      bus.ex_mem_memwrite = exwr;
      bus.dmem_ready      = rdy;
      q.push_back(exp);
      #1;
      e = q.pop_front();
      n_vec++;
      assert (obs === e) else begin
         n_miss++;
         $error("FAIL %s outputs got %b expected %b", tag, obs, e);
      end
      if (!rst_n) begin
         exp_stall = '0;
         exp_flush = '0;
      end
`ifdef PIPE_HAZARD_PERF_CNT_EN
      else begin
         if (!e[7]) exp_stall = exp_stall + 1'b1;
         if (e[6]) exp_flush = exp_flush + 1'b1;
      end
`endif
   endtask

   initial begin
      bus.if_id_rs1 = '0; bus.if_id_rs2 = '0; bus.id_ex_rd = '0; bus.id_ex_memread = 1'b0;
      bus.ex_mem_branch = 1'b0; bus.ex_mem_zero = 1'b0; bus.ex_mem_memread = 1'b0;
      bus.ex_mem_memwrite = 1'b0; bus.dmem_ready = 1'b0;
      repeat (2) @(posedge clk);
      step("rst_idle",    0, 0, 0, 0, 0, 0, 0, 0, 0, 0, NORM);
      step("rst_lu",      0, 0, 5, 5, 1, 0, 0, 0, 0, 0, LU);
      step("idle",        1, 0, 0, 0, 0, 0, 0, 0, 0, 0, NORM);
      step("lu_rs2",      1, 0, 5, 5, 1, 0, 0, 0, 0, 0, LU);
      step("lu_bubble",   1, 0, 5, 0, 0, 0, 0, 0, 0, 0, NORM);
      step("lu_rd0",      1, 0, 0, 0, 1, 0, 0, 0, 0, 0, NORM);
      step("lu_rs1",      1, 7, 3, 7, 1, 0, 0, 0, 0, 0, LU);
      step("lu_nomatch",  1, 7, 3, 9, 1, 0, 0, 0, 0, 0, NORM);
      step("br_lu",       1, 0, 5, 5, 1, 1, 1, 0, 0, 0, BR);
      step("br_nz_lu",    1, 0, 5, 5, 1, 1, 0, 0, 0, 0, LU);
      step("br_nz",       1, 0, 0, 0, 0, 1, 0, 0, 0, 0, NORM);
      step("br",          1, 0, 0, 0, 0, 1, 1, 0, 0, 0, BR);
      step("mw_start",    1, 0, 0, 0, 0, 0, 0, 1, 0, 0, HOLD);
      step("mw_c0",       1, 0, 0, 0, 0, 0, 0, 1, 0, 0, HOLD);
      step("mw_c1",       1, 0, 0, 0, 0, 0, 0, 1, 0, 0, HOLD);
      step("mw_done",     1, 0, 0, 0, 0, 0, 0, 1, 0, 1, DNORM);
      step("mw_run",      1, 0, 0, 0, 0, 0, 0, 0, 0, 0, NORM);
      step("acc_rdy",     1, 0, 0, 0, 0, 0, 0, 1, 0, 1, DNORM);
      step("bw_start",    1, 0, 0, 0, 0, 1, 1, 0, 1, 0, HOLD);
      step("bw_c0",       1, 0, 0, 0, 0, 1, 1, 0, 1, 0, HOLD);
      step("bw_done",     1, 0, 0, 0, 0, 1, 1, 0, 1, 1, DBR);
      step("bw_run",      1, 0, 0, 0, 0, 0, 0, 0, 0, 0, NORM);
      step("to_start",    1, 0, 0, 0, 0, 0, 0, 0, 1, 0, HOLD);
      step("to_c0",       1, 0, 0, 0, 0, 0, 0, 0, 1, 0, HOLD);
      step("to_c1",       1, 0, 0, 0, 0, 0, 0, 0, 1, 0, HOLD);
      step("to_c2",       1, 0, 0, 0, 0, 0, 0, 0, 1, 0, HOLD);
      step("to_c3",       1, 0, 0, 0, 0, 0, 0, 0, 1, 0, HOLD);
      step("to_halt",     1, 0, 0, 0, 0, 0, 0, 0, 1, 0, HLT);
      step("to_halt_rdy", 1, 0, 0, 0, 0, 1, 1, 0, 1, 1, HLT);
      step("to_halt_lu",  1, 0, 5, 5, 1, 0, 0, 0, 0, 0, HLT);
      step("to_rst",      0, 0, 0, 0, 0, 0, 0, 0, 0, 0, NERR);
      step("to_run",      1, 0, 0, 0, 0, 0, 0, 0, 0, 0, NORM);
      step("rw_start",    1, 0, 0, 0, 0, 0, 0, 1, 0, 0, HOLD);
      step("rw_c0",       1, 0, 0, 0, 0, 0, 0, 1, 0, 0, HOLD);
      step("rw_rst",      0, 0, 0, 0, 0, 0, 0, 1, 0, 0, HOLD);
      step("rw_idle0",    1, 0, 0, 0, 0, 0, 0, 0, 0, 0, NORM);
      step("rw_idle1",    1, 0, 0, 0, 0, 0, 0, 0, 0, 0, NORM);
      step("rw_idle2",    1, 0, 0, 0, 0, 0, 0, 0, 0, 0, NORM);
      step("rw_new",      1, 0, 0, 0, 0, 0, 0, 1, 0, 0, HOLD);
      step("rw_c0b",      1, 0, 0, 0, 0, 0, 0, 1, 0, 0, HOLD);
      step("rw_c1b",      1, 0, 0, 0, 0, 0, 0, 1, 0, 0, HOLD);
      step("rw_c2b",      1, 0, 0, 0, 0, 0, 0, 1, 0, 0, HOLD);
      step("rw_done",     1, 0, 0, 0, 0, 0, 0, 1, 0, 1, DNORM);
      step("end",         1, 0, 0, 0, 0, 0, 0, 0, 0, 0, NORM);
      step("end_perf",    1, 0, 0, 0, 0, 0, 0, 0, 0, 0, NORM);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end
endmodule
